axi_stream_pkt_arb: RTL

//  Packet-aware round-robin arbiter. Shares one if_axi_stream datapath, such as a

---
 rtl/axi_stream_pkt_arb_pkg.sv | 28 ++
 rtl/axi_stream_pkt_arb_rr_pri_sel.sv | 27 ++
 rtl/axi_stream_pkt_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/axi_stream_pkt_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
package axi_stream_pkt_arb_pkg;

    // Widest requester vector the priority helper can search.
    localparam int MAX_IN = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_e;

    // Returns the first requesting index found when scanning ptr, ptr+1 ..
    // ptr+n-1 (mod n), or -1 when nobody requests. Scanning backwards lets
    // the lowest rotated offset overwrite any later hit.
    function automatic int rr_next(input int ptr, input logic [MAX_IN-1:0] req, input int n);
        int k;
        int win;
        win = -1;
        for (int i = n - 1; i >= 0; i--) begin
            k = (ptr + i) % n;
            if (req[k[4:0]]) begin
                win = k;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axi_stream_pkt_arb_rr_pri_sel.sv
// Rotating-priority encoder: picks the first active request at or after ptr.
module axi_stream_pkt_arb_rr_pri_sel
    import axi_stream_pkt_arb_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req_i,
    input  logic [$clog2(NUM_IN)-1:0] ptr_i,
    output logic                      any_o,
    output logic [$clog2(NUM_IN)-1:0] idx_o
);

    localparam int SEL_W = $clog2(NUM_IN);

    logic [MAX_IN-1:0] reqWide;
    int                win;

    // Widen the request vector and search it starting from the pointer.
    always_comb begin
        reqWide               = '0;
        reqWide[NUM_IN-1:0]   = req_i;
        win                   = rr_next(int'(ptr_i), reqWide, NUM_IN);
        any_o                 = (win >= 0);
        idx_o                 = win[SEL_W-1:0];
    end

endmodule

// File: rtl/axi_stream_pkt_arb.sv
// Packet-aware round-robin arbiter sharing one registered stream output
// between NUM_IN requesters. A grant lasts from arbitration until the EOP beat.
module axi_stream_pkt_arb
    import axi_stream_pkt_arb_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8,
    parameter int TAG_CTL  = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_IN-1:0]                   i_if_val,
    output logic [NUM_IN-1:0]                   i_if_rdy,
    input  logic [NUM_IN*DAT_BYTS*8-1:0]        i_if_dat,
    input  logic [NUM_IN-1:0]                   i_if_sop,
    input  logic [NUM_IN-1:0]                   i_if_eop,
    input  logic [NUM_IN-1:0]                   i_if_err,
    input  logic [NUM_IN*$clog2(DAT_BYTS)-1:0]  i_if_mod,
    input  logic [NUM_IN*CTL_BITS-1:0]          i_if_ctl,
    output logic                                o_if_val,
    input  logic                                o_if_rdy,
    output logic [DAT_BYTS*8-1:0]               o_if_dat,
    output logic                                o_if_sop,
    output logic                                o_if_eop,
    output logic                                o_if_err,
    output logic [$clog2(DAT_BYTS)-1:0]         o_if_mod,
    output logic [CTL_BITS-1:0]                 o_if_ctl,
    output logic [$clog2(NUM_IN)-1:0]           o_sel,
    output logic                                o_busy
);

    localparam int SEL_W = $clog2(NUM_IN);
    localparam int DAT_W = DAT_BYTS * 8;
    localparam int MOD_W = $clog2(DAT_BYTS);

    arb_state_e        state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              firstBeat_q;

    logic              outVal_q;
    logic [DAT_W-1:0]  outDat_q;
    logic              outSop_q;
    logic              outEop_q;
    logic              outErr_q;
    logic [MOD_W-1:0]  outMod_q;
    logic [CTL_BITS-1:0] outCtl_q;

    logic              reqAny;
    logic [SEL_W-1:0]  reqIdx;
    logic              outLoad;
    logic              beatAcc;
    logic [SEL_W-1:0]  ptr_d;
    logic [DAT_W-1:0]  dat_d;
    logic              sop_d;
    logic              eop_d;
    logic              err_d;
    logic [MOD_W-1:0]  mod_d;
    logic [CTL_BITS-1:0] ctl_d;

    axi_stream_pkt_arb_rr_pri_sel #(
        .NUM_IN (NUM_IN)
    ) uPriSel (
        .req_i (i_if_val),
        .ptr_i (ptr_q),
        .any_o (reqAny),
        .idx_o (reqIdx)
    );

    // Mux the granted requester onto the output stage and decide acceptance.
    always_comb begin
        outLoad = ~outVal_q | o_if_rdy;
        beatAcc = (state_q == ARB_LOCK) && i_if_val[sel_q] && outLoad;
        dat_d   = i_if_dat[sel_q*DAT_W +: DAT_W];
        sop_d   = i_if_sop[sel_q];
        eop_d   = i_if_eop[sel_q];
        err_d   = i_if_err[sel_q] | (firstBeat_q & ~i_if_sop[sel_q]);
        mod_d   = i_if_mod[sel_q*MOD_W +: MOD_W];
        ctl_d   = i_if_ctl[sel_q*CTL_BITS +: CTL_BITS];
        if (TAG_CTL != 0) begin
            ctl_d[SEL_W-1:0] = sel_q;
        end
        ptr_d   = (sel_q == SEL_W'(NUM_IN - 1)) ? '0 : sel_q + 1'b1;
    end

    // Only the locked requester may see ready, and only when the output can load.
    always_comb begin
        i_if_rdy = '0;
        if (state_q == ARB_LOCK) begin
            i_if_rdy[sel_q] = outLoad;
        end
    end

    // Arbitration FSM plus the registered output beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            firstBeat_q <= 1'b0;
            outVal_q    <= 1'b0;
            outDat_q    <= '0;
            outSop_q    <= 1'b0;
            outEop_q    <= 1'b0;
            outErr_q    <= 1'b0;
            outMod_q    <= '0;
            outCtl_q    <= '0;
        end else begin
            if (outLoad) begin
                outVal_q <= beatAcc;
                if (beatAcc) begin
                    outDat_q <= dat_d;
                    outSop_q <= sop_d;
                    outEop_q <= eop_d;
                    outErr_q <= err_d;
                    outMod_q <= mod_d;
                    outCtl_q <= ctl_d;
                end
            end
            case (state_q)
                ARB_IDLE: begin
                    if (reqAny) begin
                        state_q     <= ARB_LOCK;
                        sel_q       <= reqIdx;
                        busy_q      <= 1'b1;
                        firstBeat_q <= 1'b1;
                    end
                end
                ARB_LOCK: begin
                    if (beatAcc) begin
                        firstBeat_q <= 1'b0;
                        if (eop_d) begin
                            state_q <= ARB_IDLE;
                            busy_q  <= 1'b0;
                            ptr_q   <= ptr_d;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_if_val = outVal_q;
    assign o_if_dat = outDat_q;
    assign o_if_sop = outSop_q;
    assign o_if_eop = outEop_q;
    assign o_if_err = outErr_q;
    assign o_if_mod = outMod_q;
    assign o_if_ctl = outCtl_q;
    assign o_sel    = sel_q;
    assign o_busy   = busy_q;

endmodule
